// File: rtl/mult_pkg.sv
// ============================================================================
// Package     : mult_pkg
// Description : Shared types for the Execute-stage iterative multiplier.
//               mult_mode_t  - operation select driven by Decode/Execute
//               mult_state_t - multiplier control sequence
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

   typedef enum logic [1:0] {
      MULT_MUL   = 2'b00,   // low half of the product
      MULT_SMULH = 2'b01,   // high half, signed operands
      MULT_UMULH = 2'b10,   // high half, unsigned operands
      MULT_RSVD  = 2'b11    // reserved encoding, behaves as MUL
   } mult_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } mult_state_t;

   // True when the operation returns the upper half of the product.
   function automatic logic mode_is_high(input mult_mode_t m);
      return (m == MULT_SMULH) || (m == MULT_UMULH);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module      : seq_multiplier
// Description : Radix-2 shift-add multiplier answering the Execute-stage
//               mult_start / stall / multiplier_done handshake. Fixed latency:
//               WIDTH iterations, one sign-fix cycle, one done cycle.
// Ports       : clk             - Execute clock, rising edge
//               reset           - asynchronous, active-high
//               mult_start      - request, sampled only while idle
//               mult_mode       - 00 MUL, 01 SMULH, 10 UMULH, 11 as MUL
//               multiplicand    - Rn operand, latched on accept
//               multiplier      - Rm operand, latched on accept
//               stall           - high while a request is pending/in flight
//               multiplier_done - one-cycle pulse, result valid that cycle
//               result          - registered product half
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mult_start,
   input  logic [1:0]       mult_mode,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   output logic             stall,
   output logic             multiplier_done,
   output logic [WIDTH-1:0] result
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   mult_state_t            state_q,  state_d;
   mult_mode_t             mode_q,   mode_d;
   logic                   sign_q,   sign_d;
   logic [WIDTH-1:0]       mcand_q,  mcand_d;
   logic [2*WIDTH:0]       acc_q,    acc_d;     // {carry, acc_hi, acc_lo}
   logic [CNT_W-1:0]       cnt_q,    cnt_d;
   logic [WIDTH-1:0]       result_q, result_d;

   logic [WIDTH-1:0]       w_a_abs;
   logic [WIDTH-1:0]       w_b_abs;
   logic [WIDTH:0]         w_sum;
   logic [2*WIDTH-1:0]     w_prod;
   mult_mode_t             w_mode_in;

   assign w_mode_in = mult_mode_t'(mult_mode);

   // Magnitudes for the signed-high path; the most negative value maps to
   // 2^(WIDTH-1), which is exactly its magnitude when read as unsigned.
   assign w_a_abs = multiplicand[WIDTH-1] ? (~multiplicand + WIDTH'(1)) : multiplicand;
   assign w_b_abs = multiplier[WIDTH-1]   ? (~multiplier   + WIDTH'(1)) : multiplier;

   // The carry bit is always clear after a shift, so {carry, acc_hi} is a
   // safe WIDTH+1-bit addend.
   assign w_sum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, mcand_q} : '0);

   assign w_prod = sign_q ? (~acc_q[2*WIDTH-1:0] + (2*WIDTH)'(1)) : acc_q[2*WIDTH-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         mode_q   <= MULT_MUL;
         sign_q   <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         sign_q   <= sign_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      mode_d          = mode_q;
      sign_d          = sign_q;
      mcand_d         = mcand_q;
      acc_d           = acc_q;
      cnt_d           = cnt_q;
      result_d        = result_q;
      stall           = 1'b0;
      multiplier_done = 1'b0;

      case (state_q)
         IDLE: begin
            // Combinational so Fetch holds in the very cycle of the request.
            // Reset forces IDLE asynchronously; gate here so stall drops too.
            stall = mult_start & ~reset;
            if (mult_start) begin
               mode_d  = w_mode_in;
               cnt_d   = '0;
               if (w_mode_in == MULT_SMULH) begin
                  mcand_d = w_a_abs;
                  acc_d   = {1'b0, {WIDTH{1'b0}}, w_b_abs};
                  sign_d  = multiplicand[WIDTH-1] ^ multiplier[WIDTH-1];
               end else begin
                  mcand_d = multiplicand;
                  acc_d   = {1'b0, {WIDTH{1'b0}}, multiplier};
                  sign_d  = 1'b0;
               end
               state_d = RUN;
            end
         end

         RUN: begin
            stall = 1'b1;
            // Add-then-shift: the adder result moves down one bit and its
            // LSB enters the top of the low half.
            acc_d = {1'b0, w_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            stall    = 1'b1;
            result_d = mode_is_high(mode_q) ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
            state_d  = DONE;
         end

         DONE: begin
            multiplier_done = 1'b1;
            state_d         = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier. A cycle-count model
//               derived from the handshake timing and plain 128-bit arithmetic
//               predicts stall / multiplier_done / result every cycle; directed
//               cases pin the model with hand-computed literals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_multiplier;

   localparam int W   = 64;
   localparam int LAT = W + 2;   // accept edge to done cycle

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [1:0]    mode;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          stall;
   logic          done;
   logic [W-1:0]  res;

   int checks   = 0;
   int failures = 0;

   seq_multiplier #(.WIDTH(W)) dut (
      .clk             (clk),
      .reset           (rst),
      .mult_start      (start),
      .mult_mode       (mode),
      .multiplicand    (a),
      .multiplier      (b),
      .stall           (stall),
      .multiplier_done (done),
      .result          (res)
   );

   always #5 clk = ~clk;

   // ---------------- reference arithmetic ----------------
   function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [1:0] m);
      logic [2*W-1:0] p;
      case (m)
         2'b01: begin
            p = {{W{x[W-1]}}, x} * {{W{y[W-1]}}, y};
            return p[2*W-1:W];
         end
         2'b10: begin
            p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            return p[2*W-1:W];
         end
         default: return x * y;
      endcase
   endfunction

   // ---------------- timing model ----------------
   // phase = -1 when idle, otherwise cycles elapsed since the accepting edge.
   int           m_phase = -1;
   logic [W-1:0] m_pend  = '0;
   logic [W-1:0] m_res   = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = -1;
         m_res   = '0;
      end else if (m_phase == -1) begin
         if (start) begin
            m_phase = 1;
            m_pend  = ref_mul(a, b, mode);
         end
      end else if (m_phase == LAT) begin
         m_phase = -1;
      end else begin
         m_phase = m_phase + 1;
         if (m_phase == LAT) m_res = m_pend;
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // Every-cycle compare against the model, away from the active edge.
   always @(negedge clk) begin
      logic e_stall, e_done;
      logic [W-1:0] e_res;
      if (rst) begin
         e_stall = 1'b0; e_done = 1'b0; e_res = '0;
      end else begin
         e_stall = (m_phase == -1) ? start : (m_phase <= W + 1);
         e_done  = (m_phase == LAT);
         e_res   = m_res;
      end
      check("stall",  W'(stall), W'(e_stall));
      check("done",   W'(done),  W'(e_done));
      check("result", res,       e_res);
   end

   // ---------------- directed helpers ----------------
   function automatic logic [W-1:0] rnd64();
      logic [W-1:0] v;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0: v = '0;
         1: v = '1;
         2: v = {1'b1, {(W-1){1'b0}}};
         3: v = {1'b0, {(W-1){1'b1}}};
         default: ;
      endcase
      return v;
   endfunction

   // One operation: request for a single cycle, then count cycles to done.
   // With disturb set, operands/mode churn during the run and a stray
   // start pulse is issued mid-run.
   task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] m,
                     input logic [W-1:0] exp, input string name, input bit disturb);
      int n;
      @(posedge clk); #1;
      start = 1'b1; a = x; b = y; mode = m;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (done) break;
         if (n > 200) break;
         #1;
         if (disturb) begin
            a     = rnd64();
            b     = rnd64();
            mode  = 2'($urandom_range(0, 3));
            start = (n == 10);
         end
      end
      #1 start = 1'b0;
      check({name, "_latency"}, W'(n), W'(LAT));
      check({name, "_value"},   res,   exp);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      logic [W-1:0] x, y;
      logic [1:0]   m;

      rst = 1'b1; start = 1'b0; mode = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_result", res, '0);
      check("reset_stall",  W'(stall), '0);
      start = 1'b1;
      #1;
      check("reset_stall_blocks_start", W'(stall), '0);
      start = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      op(64'd6, 64'd7, 2'b00, 64'd42, "mul_6x7", 1'b0);
      op('1, 64'd2, 2'b10, 64'd1, "umulh_ffx2", 1'b0);
      op('1, 64'd2, 2'b00, 64'hFFFF_FFFF_FFFF_FFFE, "mul_ffx2", 1'b0);
      op('1, 64'd2, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, "smulh_m1x2", 1'b0);
      op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01,
         64'h4000_0000_0000_0000, "smulh_minxmin", 1'b0);
      op(64'd9, 64'd11, 2'b11, 64'd99, "rsvd_9x11", 1'b0);
      op(64'd0, '1, 2'b10, 64'd0, "umulh_zero", 1'b0);

      // Reset part-way through the iterations.
      @(posedge clk); #1;
      start = 1'b1; a = 64'h1234_5678_9ABC_DEF0; b = 64'hFFFF_0000_FFFF_0000; mode = 2'b00;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (30) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrun_reset_stall",  W'(stall), '0);
      check("midrun_reset_done",   W'(done),  '0);
      check("midrun_reset_result", res,       '0);
      @(posedge clk); #1 rst = 1'b0;
      repeat (80) @(negedge clk);   // model confirms no stray done
      op(64'd3, 64'd5, 2'b00, 64'd15, "mul_3x5_after_reset", 1'b0);

      // Inputs churned during the run; stray start ignored.
      op(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, "smulh_disturb", 1'b1);
      repeat (80) @(negedge clk);

      // Back-to-back with start held high.
      @(posedge clk); #1;
      start = 1'b1; a = 64'd100; b = 64'd25; mode = 2'b00;
      @(posedge clk); #1;
      a = 64'd1 << 40; b = 64'd1 << 40; mode = 2'b10;   // second op: 2^80 -> high = 2^16
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (done && n < 100) begin
            check("b2b_first_cycle", W'(n), W'(LAT));
            check("b2b_first_value", res, 64'd2500);
         end else if (done) begin
            break;
         end
         if (n > 300) break;
      end
      #1 start = 1'b0;
      check("b2b_second_cycle", W'(n), W'(2 * LAT + 1));
      check("b2b_second_value", res, 64'h1_0000);

      // Randomized operations checked against the reference arithmetic.
      for (int i = 0; i < 40; i++) begin
         x = rnd64();
         y = rnd64();
         m = 2'($urandom_range(0, 3));
         op(x, y, m, ref_mul(x, y, m), "random", (i % 5) == 0);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
